// File: rtl/calc_sequencer_if.sv
// Handshake and datapath-control bundle between calc_sequencer and its environment.
// The master modport is the sequencer; slave is the memory/datapath/host side.
interface calc_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rd_en;
   logic [34:0]       imem_data;
   logic              alu_ovf;
   logic [15:0]       imm_a;
   logic [15:0]       imm_b;
   logic              sign_control;
   logic              store_prev_control;
   logic              accum_wr_en;
   logic              busy;
   logic              done;
   logic              ovf_flag;
   logic              pc_err;

   modport master (
      input  start, abort, imem_data, alu_ovf,
      output imem_addr, imem_rd_en, imm_a, imm_b, sign_control, store_prev_control,
             accum_wr_en, busy, done, ovf_flag, pc_err
   );

   modport slave (
      output start, abort, imem_data, alu_ovf,
      input  imem_addr, imem_rd_en, imm_a, imm_b, sign_control, store_prev_control,
             accum_wr_en, busy, done, ovf_flag, pc_err
   );
endinterface

// File: rtl/calc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the calculator accumulator datapath.
// Runs one program per accepted start and reports done, overflow and PC-wrap status.
module calc_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned START_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   calc_sequencer_if.master  bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StDecode, StExec} state_t;

   localparam logic [2:0] FnAddi   = 3'b001;
   localparam logic [2:0] FnSubi   = 3'b010;
   localparam logic [2:0] FnSubacc = 3'b100;
   localparam logic [2:0] FnLoad   = 3'b101;
   localparam logic [2:0] FnHalt   = 3'b111;
   localparam logic [ADDR_W-1:0] PcInit = ADDR_W'(START_PC);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [34:0]       r_ir;
   logic              r_rd_en;
   logic              r_wr_en;
   logic              r_done;
   logic              r_sign;
   logic              r_sel;
   logic              r_busy;
   logic              r_ovf;
   logic              r_pc_err;

   logic [2:0] w_dec_funct;
   logic       w_dec_write;
   logic       w_pc_max;

   assign w_dec_funct = bus.imem_data[34:32];
   assign w_dec_write = (w_dec_funct >= FnAddi) && (w_dec_funct <= FnLoad);
   assign w_pc_max    = (r_pc == {ADDR_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_pc     <= PcInit;
         r_ir     <= '0;
         r_rd_en  <= 1'b0;
         r_wr_en  <= 1'b0;
         r_done   <= 1'b0;
         r_sign   <= 1'b0;
         r_sel    <= 1'b0;
         r_busy   <= 1'b0;
         r_ovf    <= 1'b0;
         r_pc_err <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (bus.abort && (r_state != StIdle)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (bus.start) begin
                     r_pc     <= PcInit;
                     r_ovf    <= 1'b0;
                     r_pc_err <= 1'b0;
                     r_busy   <= 1'b1;
                     r_rd_en  <= 1'b1;
                     r_state  <= StFetch;
                  end
               end
               StFetch: r_state <= StDecode;
               StDecode: begin
                  // EXEC-cycle strobes are decoded from the arriving word so they can be registered.
                  r_ir    <= bus.imem_data;
                  r_wr_en <= w_dec_write;
                  r_done  <= (w_dec_funct == FnHalt) || w_pc_max;
                  if (w_dec_write) begin
                     r_sign <= (w_dec_funct == FnSubi) || (w_dec_funct == FnSubacc);
                     r_sel  <= (w_dec_funct == FnAddi) || (w_dec_funct == FnSubi) ||
                               (w_dec_funct == FnLoad);
                  end
                  r_state <= StExec;
               end
               StExec: begin
                  if (r_wr_en && bus.alu_ovf) r_ovf <= 1'b1;
                  if (r_ir[34:32] == FnHalt) begin
                     r_busy  <= 1'b0;
                     r_state <= StIdle;
                  end else if (w_pc_max) begin
                     r_pc_err <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= StIdle;
                  end else begin
                     r_pc    <= r_pc + 1'b1;
                     r_rd_en <= 1'b1;
                     r_state <= StFetch;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // abort must kill the write and the done pulse within the cycle it is raised.
   assign bus.accum_wr_en        = r_wr_en & ~bus.abort;
   assign bus.done               = r_done & ~bus.abort;
   assign bus.imem_addr          = r_pc;
   assign bus.imem_rd_en         = r_rd_en;
   assign bus.imm_a              = r_ir[31:16];
   assign bus.imm_b              = (r_ir[34:32] == FnLoad) ? 16'h0000 : r_ir[15:0];
   assign bus.sign_control       = r_sign;
   assign bus.store_prev_control = r_sel;
   assign bus.busy               = r_busy;
   assign bus.ovf_flag           = r_ovf;
   assign bus.pc_err             = r_pc_err;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Multi-cycle controller for the limited-function calculator datapath. It fetches 35-bit instructions from instruction memory, decodes them, and sequences the accumulator datapath one instruction at a time. It drives the add/subtract sign select, the novel-operation mux select, the accumulator write enable and the program counter. It replaces the free-running program counter and always-enabled accumulator with a start/done-controlled run.

## Interface
Parameters:
- ADDR_W, 8: instruction memory address width (word addressed).
- START_PC, 0: PC value loaded at reset and on every accepted start.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a program run; accepted only in IDLE.
- abort  in  1  synchronous abandon of the current run.
- imem_addr  out  ADDR_W  instruction address; equals the PC.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_data  in  35  instruction; valid exactly one cycle after imem_rd_en.
- alu_ovf  in  1  overflow from the add/sub unit; sampled only when accum_wr_en=1.
- imm_a  out  16  immediate A, to sign extend A.
- imm_b  out  16  immediate B, to sign extend B.
- sign_control  out  1  1 = subtract, 0 = add.
- store_prev_control  out  1  mux select: 0 = accumulator output, 1 = immediate B.
- accum_wr_en  out  1  accumulator write enable.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when HALT completes.
- ovf_flag  out  1  sticky overflow for the current run.
- pc_err  out  1  sticky PC wrap error for the current run.

## Operation
- Instruction fields:
  - [34:32] funct
  - [31:16] imm_a
  - [15:0] imm_b
- funct codes:
  - 000 NOP: no write.
  - 001 ADDI: acc = A + B; sign 0, sel 1.
  - 010 SUBI: acc = A − B; sign 1, sel 1.
  - 011 ADDACC: acc = A + acc; sign 0, sel 0.
  - 100 SUBACC: acc = A − acc; sign 1, sel 0.
  - 101 LOAD: acc = A + 0. Drive imm_b = 0, sign 0, sel 1.
  - 110: reserved, treated as NOP.
  - 111 HALT.
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE:
  - start=1 → PC ← START_PC; clear ovf_flag and pc_err; go to FETCH.
- FETCH:
  - imem_rd_en=1, imem_addr=PC; go to DECODE.
- DECODE:
  - Latch imem_data into the instruction register; go to EXEC.
- EXEC:
  - Drive imm_a, imm_b and the control selects from the instruction register.
  - accum_wr_en=1 for the write-type codes (001–101).
  - HALT → done=1 this cycle, go to IDLE, PC unchanged.
  - Any other code → PC ← PC+1, go to FETCH.
- PC wrap: if an EXEC that is not HALT occurs at PC = 2^ADDR_W−1, set pc_err, assert done, and go to IDLE. The accumulator write for that instruction still occurs.
- ovf_flag is set when accum_wr_en=1 and alu_ovf=1. It holds until the next accepted start.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - accum_wr_en is forced low in that same cycle.
  - No done pulse; flags retain their values.
  - abort takes priority over start and over HALT.
- start while busy is ignored.
- Outputs outside EXEC: imm_a, imm_b, sign_control, store_prev_control hold their last values; accum_wr_en=0.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, PC=START_PC, instruction register=0. All outputs 0, except imem_addr=START_PC.
- Release from reset takes effect on the first rising edge with rst_n=1.
- Cost is 3 cycles per instruction (FETCH, DECODE, EXEC).
- The accumulator updates on the edge that ends EXEC.
- Timeline with start sampled high at edge 0:
  - busy=1 from edge 0.
  - First imem_rd_en in cycle 1.
  - First accum_wr_en in cycle 3.
- A program of N non-HALT instructions followed by HALT asserts done in cycle 3(N+1). busy falls on the following edge.
- done and busy are both high in the HALT EXEC cycle.
- rst_n asserted mid-run: immediate IDLE, no further writes.

## Test plan
- Reset: hold rst_n=0 mid-EXEC → accum_wr_en drops asynchronously; imem_addr=START_PC; busy=0, done=0.
- Program LOAD 5; ADDI A=3 B=4; SUBACC A=20; HALT → write enables in cycles 3, 6, 9; done in cycle 12. Final sign/sel pattern: (0,1), (0,1), (1,0).
- ADDI A=0x7FFF B=0x0001 with alu_ovf driven 1 on that write → ovf_flag=1 after the write; a new start clears it.
- ADDR_W=2, four NOPs with no HALT → pc_err=1 and done pulses after the EXEC at PC=3; the PC is not written to 0.
- abort asserted during the DECODE of the second instruction → IDLE next cycle; no accum_wr_en and no done for that instruction.
- start pulsed while busy → ignored; PC and flags are unaffected.
